// File: rtl/riscv_defines.sv
// Shared definitions for the interrupt arbiter: privilege levels, FSM states
// and the width of an interrupt ID.
package riscv_defines;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } PrivLvl_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_DONE    = 2'd2
    } irq_state_t;

    localparam int IRQ_ID_W = 5;

endpackage

// File: rtl/riscv_irq_arbiter_if.sv
// Request/acknowledge handshake between the interrupt arbiter (master) and
// the core controller (slave).
interface riscv_irq_arbiter_if;
    import riscv_defines::*;

    logic                ctrl_ack_i;
    logic                ctrl_kill_i;
    logic                irq_req_ctrl_o;
    logic                irq_sec_ctrl_o;
    logic [IRQ_ID_W-1:0] irq_id_ctrl_o;

    modport master (
        input  ctrl_ack_i,
        input  ctrl_kill_i,
        output irq_req_ctrl_o,
        output irq_sec_ctrl_o,
        output irq_id_ctrl_o
    );

    modport slave (
        output ctrl_ack_i,
        output ctrl_kill_i,
        input  irq_req_ctrl_o,
        input  irq_sec_ctrl_o,
        input  irq_id_ctrl_o
    );

endinterface

// File: rtl/riscv_irq_prio_enc.sv
// Fixed-priority encoder: the highest set request index wins, reported
// zero-extended to an interrupt ID.
module riscv_irq_prio_enc
    import riscv_defines::*;
#(
    parameter int N_IRQ = 32
) (
    input  logic [N_IRQ-1:0]    req,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] id
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (req[i]) begin
                id = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Interrupt arbiter: selects the highest enabled line and hands it to the
// controller. Define RISCV_IRQ_EDGE_EN for edge-triggered (pending) mode.
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter int N_IRQ       = 32,
    parameter int PULP_SECURE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_IRQ-1:0]    irq_i,
    input  logic [N_IRQ-1:0]    irq_sec_i,
    input  logic [N_IRQ-1:0]    irq_mask_i,
    input  logic                m_IE_i,
    input  logic                u_IE_i,
    input  PrivLvl_t            current_priv_lvl_i,
    riscv_irq_arbiter_if.master ctrl,
    output logic                irq_ack_o,
    output logic [IRQ_ID_W-1:0] irq_ack_id_o
);

    irq_state_t          state_reg, state_next;
    logic [IRQ_ID_W-1:0] id_reg, id_next;
    logic                sec_reg, sec_next;
    logic                ack_reg, ack_next;
    logic [IRQ_ID_W-1:0] ack_id_reg, ack_id_next;

    logic [N_IRQ-1:0]    src;
    logic [N_IRQ-1:0]    cand;
    logic                enc_valid;
    logic [IRQ_ID_W-1:0] enc_id;
    logic [31:0]         sec_ext;
    logic                cand_sec;
    logic                glob_en;
    logic                ack_take;

    assign ack_take = (state_reg == IRQ_PENDING) && ctrl.ctrl_ack_i;

`ifdef RISCV_IRQ_EDGE_EN
    logic [N_IRQ-1:0] pending_reg, pending_next;
    logic [N_IRQ-1:0] edge_hist_reg;
    logic             armed_reg;
    logic [N_IRQ-1:0] edge_set;
    logic [31:0]      ack_clr;

    // armed_reg masks the first cycle after reset so lines already high
    // at release are not mistaken for rising edges.
    assign edge_set     = irq_i & ~edge_hist_reg & {N_IRQ{armed_reg}};
    assign ack_clr      = ack_take ? (32'd1 << id_reg) : 32'd0;
    assign pending_next = (pending_reg & ~ack_clr[N_IRQ-1:0]) | edge_set;
    assign src          = pending_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg   <= '0;
            edge_hist_reg <= '0;
            armed_reg     <= 1'b0;
        end else begin
            pending_reg   <= pending_next;
            edge_hist_reg <= irq_i;
            armed_reg     <= 1'b1;
        end
    end
`else
    assign src = irq_i;
`endif

    assign cand = src & irq_mask_i;

    riscv_irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio_enc (
        .req   (cand),
        .valid (enc_valid),
        .id    (enc_id)
    );

    assign sec_ext  = 32'(irq_sec_i);
    assign cand_sec = sec_ext[enc_id];

    generate
        if (PULP_SECURE != 0) begin : g_secure
            // A secure line may interrupt user mode even with u_IE_i clear.
            assign glob_en = ((u_IE_i | cand_sec) && (current_priv_lvl_i == PRIV_LVL_U)) ||
                             (m_IE_i && (current_priv_lvl_i == PRIV_LVL_M));
        end else begin : g_plain
            logic unused_sec_inputs;
            assign unused_sec_inputs = ^{u_IE_i, current_priv_lvl_i, cand_sec};
            assign glob_en           = m_IE_i;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            id_reg     <= '0;
            sec_reg    <= 1'b0;
            ack_reg    <= 1'b0;
            ack_id_reg <= '0;
        end else begin
            state_reg  <= state_next;
            id_reg     <= id_next;
            sec_reg    <= sec_next;
            ack_reg    <= ack_next;
            ack_id_reg <= ack_id_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        id_next     = id_reg;
        sec_next    = sec_reg;
        ack_next    = 1'b0;
        ack_id_next = '0;
        case (state_reg)
            IDLE: begin
                if (glob_en && enc_valid) begin
                    state_next = IRQ_PENDING;
                    id_next    = enc_id;
                    sec_next   = cand_sec;
                end
            end
            IRQ_PENDING: begin
                // Ack takes precedence over a simultaneous kill.
                if (ack_take) begin
                    state_next  = IRQ_DONE;
                    ack_next    = 1'b1;
                    ack_id_next = id_reg;
                end else if (ctrl.ctrl_kill_i) begin
                    state_next = IDLE;
                end
            end
            IRQ_DONE: begin
                sec_next   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ctrl.irq_req_ctrl_o = (state_reg == IRQ_PENDING);
    assign ctrl.irq_sec_ctrl_o = sec_reg;
    assign ctrl.irq_id_ctrl_o  = id_reg;
    assign irq_ack_o           = ack_reg;
    assign irq_ack_id_o        = ack_id_reg;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Self-checking bench: a plain and a secure arbiter driven side by side and
// compared every cycle against a behavioural model, plus directed sequences.
module tb_riscv_irq_arbiter;
    import riscv_defines::*;

`ifdef RISCV_IRQ_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam int LAT = EDGE ? 2 : 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] irq, irq_sec, irq_mask;
    logic        m_ie, u_ie, ack, kill;
    PrivLvl_t    priv;
    logic        ack_o0, ack_o1;
    logic [4:0]  ack_id_o0, ack_id_o1;

    riscv_irq_arbiter_if if0 ();
    riscv_irq_arbiter_if if1 ();
    assign if0.ctrl_ack_i  = ack;
    assign if0.ctrl_kill_i = kill;
    assign if1.ctrl_ack_i  = ack;
    assign if1.ctrl_kill_i = kill;

    riscv_irq_arbiter #(.N_IRQ(32), .PULP_SECURE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_sec_i(irq_sec), .irq_mask_i(irq_mask),
        .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv), .ctrl(if0),
        .irq_ack_o(ack_o0), .irq_ack_id_o(ack_id_o0));

    riscv_irq_arbiter #(.N_IRQ(32), .PULP_SECURE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .irq_i(irq), .irq_sec_i(irq_sec), .irq_mask_i(irq_mask),
        .m_IE_i(m_ie), .u_IE_i(u_ie), .current_priv_lvl_i(priv), .ctrl(if1),
        .irq_ack_o(ack_o1), .irq_ack_id_o(ack_id_o1));

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = waiting, 1 = request held, 2 = acknowledged.
    int          m_phase [2];
    logic [4:0]  m_id    [2];
    logic        m_sec   [2];
    logic        m_ack   [2];
    logic [4:0]  m_ack_id[2];
    logic [31:0] m_pend  [2];
    logic [31:0] m_prev;
    bit          m_armed;

    function automatic int highest(input logic [31:0] v);
        for (int k = 31; k >= 0; k--) if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_id[d] = '0; m_sec[d] = 1'b0;
            m_ack[d] = 1'b0; m_ack_id[d] = '0; m_pend[d] = '0;
        end
        m_prev  = '0;
        m_armed = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] edges, cand;
        int          w;
        logic        sec_c, en;
        edges = (EDGE && m_armed) ? (irq & ~m_prev) : 32'd0;
        for (int d = 0; d < 2; d++) begin
            cand  = (EDGE ? m_pend[d] : irq) & irq_mask;
            w     = highest(cand);
            sec_c = (w >= 0) ? irq_sec[w] : 1'b0;
            if (d == 0) en = m_ie;
            else en = ((u_ie || sec_c) && priv == PRIV_LVL_U) || (m_ie && priv == PRIV_LVL_M);
            m_ack[d]    = 1'b0;
            m_ack_id[d] = '0;
            case (m_phase[d])
                0: if (en && w >= 0) begin
                    m_phase[d] = 1; m_id[d] = 5'(w); m_sec[d] = sec_c;
                end
                1: if (ack) begin
                    m_phase[d] = 2; m_ack[d] = 1'b1; m_ack_id[d] = m_id[d];
                    if (EDGE) m_pend[d][m_id[d]] = 1'b0;
                end else if (kill) begin
                    m_phase[d] = 0;
                end
                default: begin m_phase[d] = 0; m_sec[d] = 1'b0; end
            endcase
            if (EDGE) m_pend[d] = m_pend[d] | edges;
        end
        m_prev  = irq;
        m_armed = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("req0", 32'(if0.irq_req_ctrl_o), 32'(m_phase[0] == 1));
        chk("id0",  32'(if0.irq_id_ctrl_o),  32'(m_id[0]));
        chk("sec0", 32'(if0.irq_sec_ctrl_o), 32'(m_sec[0]));
        chk("ack0", 32'(ack_o0),             32'(m_ack[0]));
        chk("ackid0", 32'(ack_id_o0),        32'(m_ack_id[0]));
        chk("req1", 32'(if1.irq_req_ctrl_o), 32'(m_phase[1] == 1));
        chk("id1",  32'(if1.irq_id_ctrl_o),  32'(m_id[1]));
        chk("sec1", 32'(if1.irq_sec_ctrl_o), 32'(m_sec[1]));
        chk("ack1", 32'(ack_o1),             32'(m_ack[1]));
        chk("ackid1", 32'(ack_id_o1),        32'(m_ack_id[1]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        $display("t=%0t irq=%h mask=%h ack=%b kill=%b | req=%b/%b id=%0d/%0d ackp=%b/%b",
                 $time, irq, irq_mask, ack, kill, if0.irq_req_ctrl_o, if1.irq_req_ctrl_o,
                 if0.irq_id_ctrl_o, if1.irq_id_ctrl_o, ack_o0, ack_o1);
        check_all();
    endtask

    task automatic reset_dut();
        ack = 1'b0; kill = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    typedef struct {
        logic [31:0] irq;
        logic [31:0] mask;
        logic        m_ie;
        logic        exp_req;
        logic [4:0]  exp_id;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst_n = 1'b0; irq = '0; irq_sec = '0; irq_mask = '0;
        m_ie = 1'b0; u_ie = 1'b0; ack = 1'b0; kill = 1'b0; priv = PRIV_LVL_M;
        model_reset();
        #2;
        chk("rst_req0", 32'(if0.irq_req_ctrl_o), 0);
        chk("rst_ack0", 32'(ack_o0), 0);
        chk("rst_ackid0", 32'(ack_id_o0), 0);
        #10;
        rst_n = 1'b1;

        vecs[0] = '{32'h0000_0410, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd10};
        vecs[1] = '{32'h0000_0008, 32'h0000_0000, 1'b1, 1'b0, 5'd0};
        vecs[2] = '{32'h0000_0008, 32'h0000_0008, 1'b1, 1'b1, 5'd3};
        vecs[3] = '{32'h0000_0008, 32'h0000_0008, 1'b0, 1'b0, 5'd0};
        vecs[4] = '{32'h8000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd31};
        vecs[5] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1, 5'd0};
        vecs[6] = '{32'h0000_00F0, 32'h0000_0030, 1'b1, 1'b1, 5'd5};
        vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0};

        // Table: selection and enables, latency LAT from idle.
        for (int i = 0; i < 8; i++) begin
            irq = '0; irq_mask = '0; priv = PRIV_LVL_M;
            reset_dut();
            irq = vecs[i].irq; irq_mask = vecs[i].mask; m_ie = vecs[i].m_ie;
            repeat (LAT) tick();
            chk($sformatf("tbl%0d_req", i), 32'(if0.irq_req_ctrl_o), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) chk($sformatf("tbl%0d_id", i), 32'(if0.irq_id_ctrl_o), 32'(vecs[i].exp_id));
            irq = '0;
        end

        // Ack handshake on ID 10.
        irq = '0; m_ie = 1'b1; irq_mask = '1;
        reset_dut();
        irq = 32'h0000_0410;
        repeat (LAT) tick();
        chk("hs_req", 32'(if0.irq_req_ctrl_o), 1);
        ack = 1'b1; tick(); ack = 1'b0; irq = '0;
        chk("hs_ack", 32'(ack_o0), 1);
        chk("hs_ackid", 32'(ack_id_o0), 10);
        chk("hs_req_done", 32'(if0.irq_req_ctrl_o), 0);
        tick();
        chk("hs_ack_gone", 32'(ack_o0), 0);
        chk("hs_ackid_gone", 32'(ack_id_o0), 0);

        // Ack and kill together on ID 5: ack wins.
        irq = '0; reset_dut();
        irq = 32'h20;
        repeat (LAT) tick();
        ack = 1'b1; kill = 1'b1; tick(); ack = 1'b0; kill = 1'b0;
        chk("ackkill_ack", 32'(ack_o0), 1);
        chk("ackkill_id", 32'(ack_id_o0), 5);

        // Dropping line and mask does not withdraw; kill does.
        irq = '0; reset_dut();
        irq = 32'h4;
        repeat (LAT) tick();
        irq = '0; irq_mask = '0; tick();
        chk("hold_req", 32'(if0.irq_req_ctrl_o), 1);
        chk("hold_id", 32'(if0.irq_id_ctrl_o), 2);
        kill = 1'b1; tick(); kill = 1'b0;
        chk("kill_req", 32'(if0.irq_req_ctrl_o), 0);
        irq_mask = '1;

        // Reset during the ack cycle: no ack pulse.
        irq = '0; reset_dut();
        irq = 32'h100;
        repeat (LAT) tick();
        ack = 1'b1; rst_n = 1'b0; model_reset();
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(ack_o0), 0);
        chk("rst_mid_req", 32'(if0.irq_req_ctrl_o), 0);
        ack = 1'b0; irq = '0;
        #2; rst_n = 1'b1;

        // Secure gating in user mode.
        irq = '0; reset_dut();
        priv = PRIV_LVL_U; u_ie = 1'b0; m_ie = 1'b0; irq_sec = 32'h4; irq = 32'h4;
        repeat (LAT) tick();
        chk("sec_req1", 32'(if1.irq_req_ctrl_o), 1);
        chk("sec_id1", 32'(if1.irq_id_ctrl_o), 2);
        chk("sec_bit1", 32'(if1.irq_sec_ctrl_o), 1);
        chk("sec_req0", 32'(if0.irq_req_ctrl_o), 0);
        rst_n = 1'b0; model_reset(); #1;
        chk("sec_rst_req", 32'(if1.irq_req_ctrl_o), 0);
        chk("sec_rst_sec", 32'(if1.irq_sec_ctrl_o), 0);
        chk("sec_rst_id", 32'(if1.irq_id_ctrl_o), 0);
        #3; rst_n = 1'b1;
        irq = '0; irq_sec = '0; reset_dut();
        irq = 32'h4;
        repeat (LAT + 1) tick();
        chk("nosec_req1", 32'(if1.irq_req_ctrl_o), 0);
        priv = PRIV_LVL_M; m_ie = 1'b1; irq = '0;

`ifdef RISCV_IRQ_EDGE_EN
        // Single-cycle pulse, kill re-arbitrates, ack clears.
        reset_dut();
        irq = 32'h80; tick(); irq = '0; tick();
        chk("edge_req", 32'(if0.irq_req_ctrl_o), 1);
        chk("edge_id", 32'(if0.irq_id_ctrl_o), 7);
        kill = 1'b1; tick(); kill = 1'b0;
        chk("edge_kill", 32'(if0.irq_req_ctrl_o), 0);
        tick();
        chk("edge_rereq", 32'(if0.irq_req_ctrl_o), 1);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("edge_ack", 32'(ack_o0), 1);
        repeat (3) tick();
        chk("edge_cleared", 32'(if0.irq_req_ctrl_o), 0);
        // New edge in the ack cycle survives the clear.
        irq = 32'h80; tick(); irq = '0; tick();
        ack = 1'b1; irq = 32'h80; tick(); ack = 1'b0; irq = '0;
        tick(); tick();
        chk("edge_win_req", 32'(if0.irq_req_ctrl_o), 1);
        chk("edge_win_id", 32'(if0.irq_id_ctrl_o), 7);
        // Line held high through reset release is not an edge.
        irq = 32'h1; reset_dut();
        repeat (3) tick();
        chk("edge_held_high", 32'(if0.irq_req_ctrl_o), 0);
        irq = '0;
`endif

        // Randomised traffic against the model.
        reset_dut();
        for (int n = 0; n < 400; n++) begin
            irq      = $urandom & $urandom;
            irq_mask = $urandom | $urandom;
            irq_sec  = $urandom;
            m_ie     = ($urandom_range(0, 7) != 0);
            u_ie     = $urandom_range(0, 1) == 1;
            priv     = ($urandom_range(0, 1) == 1) ? PRIV_LVL_M : PRIV_LVL_U;
            ack      = ($urandom_range(0, 3) == 0);
            kill     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) reset_dut();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_irq_arbiter.md
RISCV_IRQ_ARBITER -- requirements
Module: riscv_irq_arbiter

Interface
REQ-001 SHALL have parameter N_IRQ, default 32, number of interrupt lines; legal range 1..32.
REQ-002 SHALL have parameter PULP_SECURE, default 0, enables user-mode/secure interrupt gating.
REQ-003 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port irq_i  input  N_IRQ  interrupt request lines, one bit per ID.
REQ-006 SHALL have port irq_sec_i  input  N_IRQ  per-line secure attribute.
REQ-007 SHALL have port irq_mask_i  input  N_IRQ  per-line enable; 1 = line may be selected.
REQ-008 SHALL have ports m_IE_i, u_IE_i  input  1 each  global M/U interrupt enables from CSR.
REQ-009 SHALL have port current_priv_lvl_i  input  PrivLvl_t  current privilege level.
REQ-010 SHALL have ports ctrl_ack_i, ctrl_kill_i  input  1 each  controller handshake.
REQ-011 SHALL have port irq_req_ctrl_o  output  1  interrupt request to controller.
REQ-012 SHALL have ports irq_sec_ctrl_o  output  1 and irq_id_ctrl_o  output  5  secure bit and ID of the held request.
REQ-013 SHALL have ports irq_ack_o  output  1 and irq_ack_id_o  output  5  one-cycle acknowledge pulse and acknowledged ID, returned to the interrupt source.

Function
REQ-014 Global enable SHALL be m_IE_i when PULP_SECURE=0; otherwise ((u_IE_i | sec of candidate) & priv==PRIV_LVL_U) | (m_IE_i & priv==PRIV_LVL_M).
REQ-015 The candidate vector SHALL be src & irq_mask_i, where src is irq_i (level mode) or the pending register (edge mode, REQ-030).
REQ-016 Selection SHALL be fixed priority: the highest set index wins; the ID is zero-extended to 5 bits.
REQ-017 FSM states SHALL be IDLE, IRQ_PENDING and IRQ_DONE, with irq_req_ctrl_o = (state==IRQ_PENDING).
REQ-018 IDLE: on global enable & any candidate bit set, SHALL go to IRQ_PENDING and latch the winner's ID and secure bit; otherwise it stays in IDLE.
REQ-019 IRQ_PENDING: on ctrl_ack_i it SHALL go to IRQ_DONE; on ctrl_kill_i alone it SHALL go to IDLE; otherwise it holds, keeping the latched ID and secure bit stable.
REQ-020 Simultaneous ack and kill SHALL be treated as ack.
REQ-021 The ack cycle SHALL register irq_ack_o=1 and irq_ack_id_o=latched ID, so both are visible during IRQ_DONE only.
REQ-022 IRQ_DONE SHALL clear the secure latch and return to IDLE unconditionally; a new selection is possible no earlier than the following cycle.
REQ-023 Latency from a qualifying line to irq_req_ctrl_o SHALL be 1 cycle from IDLE in level mode and 2 cycles in edge mode.
REQ-024 Deasserting irq_i or its mask while in IRQ_PENDING SHALL NOT withdraw the request; only kill withdraws it.
REQ-025 Kill SHALL leave the pending state untouched, so the interrupt is re-arbitrated from IDLE.

Reset
REQ-026 While rst_n=0, state SHALL be IDLE and the ID latch, secure latch, irq_ack_o, irq_ack_id_o, pending register and edge-history register SHALL all be 0.
REQ-027 Every output SHALL read 0 during reset.
REQ-028 Reset asserted mid-handshake SHALL abort immediately with no ack pulse.
REQ-029 Lines held high at reset release SHALL NOT register as edges.

Configuration
REQ-030 Macro RISCV_IRQ_EDGE_EN SHALL select edge mode when defined; in edge mode a 0->1 transition on irq_i[k] sets pending[k].
REQ-031 In edge mode the ack cycle SHALL clear pending[ID]; a new edge on the same bit in that cycle SHALL win, leaving the bit set.
REQ-032 Without the macro, the block SHALL be level-sensitive with no pending or edge-history registers synthesised.

Structure
REQ-033 Shared package riscv_defines SHALL hold PrivLvl_t and the FSM state enum type.
REQ-034 The priority encoder SHALL be a sub-module riscv_irq_prio_enc, parameterised by N_IRQ, with outputs valid and id.

Verification
REQ-035 N_IRQ=32, m_IE_i=1, irq_i=0x0000_0410, mask all 1 -> irq_req_ctrl_o=1 after 1 cycle, irq_id_ctrl_o=10.
REQ-036 Same setup, ctrl_ack_i pulsed -> next cycle irq_ack_o=1, irq_ack_id_o=10, irq_req_ctrl_o=0; IDLE the cycle after.
REQ-037 irq_i=0x8, mask=0x0 -> no request; mask=0x8 -> request ID 3; m_IE_i=0 with mask=0x8 -> no request.
REQ-038 Pending ID 5, ack and kill asserted together -> ack path taken, irq_ack_o=1.
REQ-039 RISCV_IRQ_EDGE_EN defined: single-cycle pulse on irq_i[7] -> request ID 7 two cycles later; kill -> re-requested; ack -> pending[7] cleared, no further request.
REQ-040 PULP_SECURE=1, priv=U, u_IE_i=0, irq_sec_i[2]=1, irq_i=0x4 -> request ID 2 with irq_sec_ctrl_o=1; rst_n dropped while pending -> all outputs 0 immediately.
